// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential byte prefetcher feeding a DEPTH-entry FIFO, with flush-and-redirect.
module prefetch_queue #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  output logic [ADDR_WIDTH-1:0]   memAddr,
  output logic                    memStrobe,
  input  logic [7:0]              memDataRead,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   flushAddr,
  output logic                    popValid,
  output logic [7:0]              popData,
  output logic [ADDR_WIDTH-1:0]   popAddr,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + $clog2(MEM_LATENCY + 1) + 1;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, head_addr_q, head_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [SW-1:0] inflight;
  logic wr, rd;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + SW'(vld_q[i]);
  end
  // Credits cover queued bytes plus reads still in the memory pipe, so the FIFO never overflows.
  assign memStrobe = resetN & ~flush & ((SW'(count_q) + inflight) < SW'(DEPTH));
  assign memAddr   = fetch_addr_q;
  assign popValid  = resetN & (count_q != '0);
  assign popData   = mem_q[rd_ptr_q];
  assign popAddr   = head_addr_q;
  assign count     = resetN ? count_q : '0;
  assign wr        = vld_q[MEM_LATENCY-1] & ~flush;
  assign rd        = pop & popValid & ~flush;
  always_comb begin
    fetch_addr_d = flush ? flushAddr : fetch_addr_q + ADDR_WIDTH'(memStrobe);
    head_addr_d  = flush ? flushAddr : head_addr_q + ADDR_WIDTH'(rd);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + PW'(rd);
    wr_ptr_d     = flush ? '0 : wr_ptr_q + PW'(wr);
    count_d      = flush ? '0 : count_q + CW'(wr) - CW'(rd);
    vld_d        = flush ? '0 : (vld_q << 1) | MEM_LATENCY'(memStrobe);
    mem_d        = mem_q;
    if (wr) mem_d[wr_ptr_q] = memDataRead;
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fetch_addr_q <= '0;
      head_addr_q  <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      vld_q        <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_addr_q  <= head_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      vld_q        <= vld_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule
